// File: rtl/seq_mult.sv
// seq_mult: radix-2 shift-add multiplier, one partial product per clock.
// Optional signed mode works on magnitudes and negates the result in FIX.
module seq_mult #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
  localparam logic [PW-1:0]    ONE_P  = PW'(1);
  localparam logic [CW-1:0]    CNT_LD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_1  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic [PW-1:0]    r_prod;

  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_accept;
  logic [PW-1:0]    w_acc_add;
  logic [PW-1:0]    w_fixed;

  // signed mode only exists when the build enables it
  generate
    if (SIGNED_EN) begin : g_sgn
      assign w_sgn = is_signed;
    end else begin : g_uns
      assign w_sgn = 1'b0;
    end
  endgenerate

  assign w_a_neg = w_sgn & a[WIDTH-1];
  assign w_b_neg = w_sgn & b[WIDTH-1];

  // -2^(W-1) negates to itself, which reads back as +2^(W-1) unsigned
  assign w_a_mag = w_a_neg ? (~a + ONE_W) : a;
  assign w_b_mag = w_b_neg ? (~b + ONE_W) : b;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_acc_add = r_acc + r_mcand;
  assign w_fixed   = r_neg ? (~r_acc + ONE_P) : r_acc;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state: RUN lasts exactly WIDTH cycles
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN:  if (r_cnt == CNT_1) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // operand capture and shift-add iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_cnt    <= CNT_LD;
      r_neg    <= w_a_neg ^ w_b_neg;
    end else if (r_state == S_RUN) begin
      if (r_mplier[0]) begin
        r_acc <= w_acc_add;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_1;
    end
  end

  // result register, written only in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
    end else if (r_state == S_FIX) begin
      r_prod <= w_fixed;
    end
  end

  assign busy    = (r_state == S_RUN) || (r_state == S_FIX);
  assign done    = (r_state == S_DONE);
  assign product = r_prod;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed vectors for WIDTH=8 plus
// exhaustive WIDTH=3 sweep of both modes.
module tb_seq_mult;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        st8 = 1'b0;
  logic        sg8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;

  logic        st3 = 1'b0;
  logic        sg3 = 1'b0;
  logic [2:0]  a3 = '0;
  logic [2:0]  b3 = '0;
  logic        busy3;
  logic        done3;
  logic [5:0]  p3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .is_signed(sg8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
  );

  seq_mult #(.WIDTH(3), .SIGNED_EN(1'b1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .is_signed(sg3),
    .a(a3), .b(b3), .busy(busy3), .done(done3), .product(p3)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sg;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic s);
    logic signed [15:0] sp;
    logic [15:0] up;
    sp = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
    up = {8'd0, x} * {8'd0, y};
    return s ? sp : up;
  endfunction

  function automatic logic [5:0] ref3(input logic [2:0] x,
                                      input logic [2:0] y,
                                      input logic s);
    logic signed [5:0] sp;
    logic [5:0] up;
    sp = $signed({{3{x[2]}}, x}) * $signed({{3{y[2]}}, y});
    up = {3'd0, x} * {3'd0, y};
    return s ? sp : up;
  endfunction

  // 3-bit combinational array multiplier: AND rows summed
  function automatic logic [5:0] arr3(input logic [2:0] x,
                                      input logic [2:0] y);
    logic [5:0] r0, r1, r2;
    r0 = {3'd0, x & {3{y[0]}}};
    r1 = {2'd0, x & {3{y[1]}}, 1'b0};
    r2 = {1'b0, x & {3{y[2]}}, 2'b0};
    return r0 + r1 + r2;
  endfunction

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                        input logic ts, input logic [15:0] exp,
                        input string nm);
    int lat;
    int bc;
    lat = 0;
    bc = 0;
    @(negedge clk);
    a8 = ta; b8 = tb; sg8 = ts; st8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    a8 = ~ta; b8 = ~tb; sg8 = ~ts;
    for (int i = 1; i <= 20; i++) begin
      if (busy8) bc++;
      @(posedge clk);
      #1;
      if (done8) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_lat"}, lat, 9);
    chk({nm, "_busy"}, bc, 9);
    chk({nm, "_prod"}, p8, exp);
    chk({nm, "_bsydn"}, busy8, 1'b0);
    @(posedge clk);
    #1;
    chk({nm, "_pulse"}, done8, 1'b0);
    chk({nm, "_hold"}, p8, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[10];
    int   mcnt;
    bit   idle;
    logic [15:0] cap;
    int   ndone;
    int   nacc;
    bit   seen;

    vt[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vt[1] = '{8'hFD, 8'h07, 1'b1, 16'hFFEB};
    vt[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vt[3] = '{8'h80, 8'h00, 1'b1, 16'h0000};
    vt[4] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    vt[5] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    vt[6] = '{8'h00, 8'hFF, 1'b1, 16'h0000};
    vt[7] = '{8'h7F, 8'h81, 1'b1, 16'hC0FF};
    vt[8] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vt[9] = '{8'h80, 8'h80, 1'b0, 16'h4000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_prod", p8, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sg, vt[i].exp,
             $sformatf("vec%0d", i));
    end

    // start held high, operands changing each cycle
    idle = 1'b1;
    mcnt = 0;
    cap = '0;
    ndone = 0;
    nacc = 0;
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; sg8 = 1'b0; st8 = 1'b1;
    for (int c = 0; c < 44; c++) begin
      @(posedge clk);
      if (idle) begin
        if (st8) begin
          cap = ref8(a8, b8, sg8);
          idle = 1'b0;
          mcnt = 0;
          nacc++;
        end
      end else begin
        mcnt++;
        if (mcnt == 10) idle = 1'b1;
      end
      #1;
      chk("hs_done", done8, (!idle && mcnt == 9));
      if (done8) begin
        ndone++;
        chk("hs_prod", p8, cap);
      end
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      sg8 = 1'($urandom_range(1, 0));
    end
    st8 = 1'b0;
    chk("hs_ndone", ndone, 4);
    chk("hs_nacc", nacc, 4);

    // abort mid-RUN with an asynchronous reset
    run_op(8'h12, 8'h34, 1'b0, 16'h03A8, "pre");
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h81; sg8 = 1'b1; st8 = 1'b1;
    @(posedge clk);
    #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("ab_busy_pre", busy8, 1'b1);
    chk("ab_prod_pre", p8, 16'h03A8);
    rst_n = 1'b0;
    #1;
    chk("ab_busy", busy8, 1'b0);
    chk("ab_done", done8, 1'b0);
    chk("ab_prod", p8, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done8) seen = 1'b1;
    end
    chk("ab_nodone", seen, 1'b0);
    chk("ab_prod_hold", p8, 16'h0);
    run_op(8'h7F, 8'h81, 1'b1, 16'hC0FF, "post");

    // WIDTH=3 exhaustive, both modes, back-to-back
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 8; ia++) begin
        for (int ib = 0; ib < 8; ib++) begin
          @(negedge clk);
          a3 = 3'(ia); b3 = 3'(ib); sg3 = 1'(s); st3 = 1'b1;
          @(posedge clk);
          #1;
          st3 = 1'b0;
          seen = 1'b0;
          for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done3) begin
              seen = 1'b1;
              break;
            end
          end
          chk($sformatf("w3_done_s%0d_%0d_%0d", s, ia, ib), seen, 1'b1);
          chk($sformatf("w3_prod_s%0d_%0d_%0d", s, ia, ib), p3,
              ref3(3'(ia), 3'(ib), 1'(s)));
          if (s == 0) begin
            chk($sformatf("w3_arr_%0d_%0d", ia, ib), p3,
                arr3(3'(ia), 3'(ib)));
          end
          @(posedge clk);
          #1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
